counter_sched: RTL and testbench
================================

COUNTER_SCHED -- requirements
Module: counter_sched

Interface
REQ-001 The block SHALL have parameter CNT_W, default 4, meaning the width of the counter value and of each step count.
REQ-002 The block SHALL have port clk, input, 1 bit, the single rising-edge clock.
REQ-003 The block SHALL have port rst, input, 1 bit, the reset: synchronous, active-high.
REQ-004 The block SHALL have port req, input, 2 bits, with one count request per requester (bit i = requester i).
REQ-005 The block SHALL have port dir, input, 2 bits, giving each requester's direction: 1 = up, 0 = down.
REQ-006 The block SHALL have port steps0, input, CNT_W bits, giving requester 0's number of count steps.
REQ-007 The block SHALL have port steps1, input, CNT_W bits, giving requester 1's number of count steps.
REQ-008 The block SHALL have port gnt, output, 2 bits, a one-hot grant that is high while that requester owns the counter.
REQ-009 The block SHALL have port done, output, 2 bits, a one-cycle completion pulse to the granted requester.
REQ-010 The block SHALL have port busy, output, 1 bit, high whenever the state is not IDLE.
REQ-011 The block SHALL have port sel, output, 1 bit, the active count direction, valid while cnt_en=1.
REQ-012 The block SHALL have port cnt_en, output, 1 bit, high in every cycle the counter steps.
REQ-013 The block SHALL have port out, output, CNT_W bits, the shared counter value.

Function
REQ-014 The FSM SHALL have exactly three states: IDLE, RUN and DONE.
REQ-015 In IDLE with req!=0, arbitration SHALL pick one requester per round robin: the priority pointer rr favours requester rr when both requests are high.
REQ-016 At the arbitrating edge the block SHALL latch dir and steps of the winner, set gnt one-hot, and go to RUN, or go directly to DONE if the latched steps==0.
REQ-017 In RUN, each edge SHALL set out to out+1 (sel=1) or out-1 (sel=0), modulo 2^CNT_W, and decrement the remaining count.
REQ-018 cnt_en and sel SHALL be driven combinationally from state RUN and the latched direction; outside RUN, cnt_en=0 and sel=0.
REQ-019 The step that brings the remaining count to 0 SHALL be the last one, and the FSM SHALL move to DONE on that same edge.
REQ-020 For steps=N>0, out SHALL change on exactly N consecutive edges after the grant edge, and done SHALL be high in the cycle after the Nth change.
REQ-021 DONE SHALL last exactly one cycle, with done[i]=gnt[i]=1; the next edge SHALL clear gnt, return the FSM to IDLE, and set rr to the other requester.
REQ-022 Wrap-around SHALL be silent: up from 2^CNT_W-1 gives 0, and down from 0 gives 2^CNT_W-1, with no flag.
REQ-023 out SHALL hold its value between jobs; there is no reload.
REQ-024 Deasserting req, or changing dir or steps, during RUN or DONE SHALL have no effect on the job in progress.
REQ-025 A req still high in IDLE after done SHALL be treated as a new request, arbitrated against the other requester under the updated rr.
REQ-026 A request arriving while busy=1 SHALL wait; it SHALL be neither lost nor queued beyond req being held.
REQ-027 gnt SHALL never have more than one bit set.

Reset
REQ-028 While rst=1 at an edge, the block SHALL set state=IDLE, rr=0, out=0, gnt=00, done=00, busy=0, cnt_en=0 and sel=0.
REQ-029 Reset SHALL take priority over every event, including mid-RUN and during DONE; an aborted job SHALL produce no done pulse.
REQ-030 After rst falls, the first arbitration SHALL be possible at the next edge.

Verification
REQ-031 Reset test: rst=1 for 2 cycles with req=11 -> gnt=00, out=0, busy=0 throughout.
REQ-032 Single up job: req=01, dir[0]=1, steps0=5, out=0 -> gnt=01 after 1 edge; out goes 1,2,3,4,5 on the next 5 edges; done=01 for 1 cycle; then gnt=00, busy=0.
REQ-033 Round robin test: both requesters request from reset and hold req=11 -> requester 0 is served first; then requester 1; then requester 0; gnt never 11.
REQ-034 Wrap test: out=0, dir=down, steps=3 -> out goes 15,14,13; done pulses after 13.
REQ-035 Zero-step test: steps1=0 with req=10 -> gnt=10, then done=10 on the next cycle; cnt_en stays 0; out unchanged.
REQ-036 Mid-run reset: rst=1 during RUN after 2 of 6 steps -> next edge gives out=0, gnt=00, no done pulse; a subsequent req=11 is granted to requester 0.

Source files
------------

// File: rtl/counter_sched.sv
`default_nettype none
// ============================================================================
// Module      : counter_sched
// Description : Two-requester round-robin scheduler sharing one up/down
//               counter; each grant runs a latched number of count steps.
// Revision    : 1.0 - initial release
// ============================================================================
module counter_sched #(
    parameter int CNT_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [1:0]       req,
    input  logic [1:0]       dir,
    input  logic [CNT_W-1:0] steps0,
    input  logic [CNT_W-1:0] steps1,
    output logic [1:0]       gnt,
    output logic [1:0]       done,
    output logic             busy,
    output logic             sel,
    output logic             cnt_en,
    output logic [CNT_W-1:0] out
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t           r_state;
    logic             r_rr;
    logic [1:0]       r_gnt;
    logic [1:0]       r_done;
    logic             r_busy;
    logic             r_dir;
    logic [CNT_W-1:0] r_rem;
    logic [CNT_W-1:0] r_out;

    logic             w_pick;
    logic             w_dir;
    logic [CNT_W-1:0] w_steps;
    logic [1:0]       w_gnt;

    // With both requests pending the pointer decides; otherwise the lone requester wins.
    always_comb begin
        w_pick  = (req == 2'b11) ? r_rr : req[1];
        w_dir   = w_pick ? dir[1] : dir[0];
        w_steps = w_pick ? steps1 : steps0;
        w_gnt   = w_pick ? 2'b10 : 2'b01;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_rr    <= 1'b0;
            r_gnt   <= 2'b00;
            r_done  <= 2'b00;
            r_busy  <= 1'b0;
            r_dir   <= 1'b0;
            r_rem   <= '0;
            r_out   <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (req != 2'b00) begin
                        r_gnt  <= w_gnt;
                        r_dir  <= w_dir;
                        r_rem  <= w_steps;
                        r_busy <= 1'b1;
                        if (w_steps == '0) begin
                            r_state <= ST_DONE;
                            r_done  <= w_gnt;
                        end else begin
                            r_state <= ST_RUN;
                        end
                    end
                end
                ST_RUN: begin
                    r_out <= r_dir ? r_out + 1'b1 : r_out - 1'b1;
                    r_rem <= r_rem - 1'b1;
                    if (r_rem == CNT_W'(1)) begin
                        r_state <= ST_DONE;
                        r_done  <= r_gnt;
                    end
                end
                ST_DONE: begin
                    r_state <= ST_IDLE;
                    r_gnt   <= 2'b00;
                    r_done  <= 2'b00;
                    r_busy  <= 1'b0;
                    // Hand priority to whichever requester was not just served.
                    r_rr    <= r_gnt[0];
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_gnt   <= 2'b00;
                    r_done  <= 2'b00;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign cnt_en = (r_state == ST_RUN);
    assign sel    = cnt_en & r_dir;
    assign gnt    = r_gnt;
    assign done   = r_done;
    assign busy   = r_busy;
    assign out    = r_out;

endmodule
`default_nettype wire

// File: tb/tb_counter_sched.sv
`default_nettype none
// ============================================================================
// Module      : tb_counter_sched
// Description : Self-checking bench for counter_sched: job table with a
//               completion scoreboard plus directed multi-cycle sequences.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_counter_sched;

    localparam int CNT_W = 4;

    logic             clk = 1'b0;
    logic             rst;
    logic [1:0]       req;
    logic [1:0]       dir;
    logic [CNT_W-1:0] steps0;
    logic [CNT_W-1:0] steps1;
    logic [1:0]       gnt;
    logic [1:0]       done;
    logic             busy;
    logic             sel;
    logic             cnt_en;
    logic [CNT_W-1:0] out;

    counter_sched #(.CNT_W(CNT_W)) dut (
        .clk    (clk),
        .rst    (rst),
        .req    (req),
        .dir    (dir),
        .steps0 (steps0),
        .steps1 (steps1),
        .gnt    (gnt),
        .done   (done),
        .busy   (busy),
        .sel    (sel),
        .cnt_en (cnt_en),
        .out    (out)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]       req;
        logic [1:0]       dir;
        logic [CNT_W-1:0] s0;
        logic [CNT_W-1:0] s1;
        logic [1:0]       gnt;
        logic [CNT_W-1:0] out;
    } vec_t;

    typedef struct {
        logic [1:0]       gnt;
        logic [CNT_W-1:0] out;
        int               steps;
    } exp_t;

    vec_t tbl[8];
    exp_t sb_q[$];
    exp_t sb_e;
    int   n_checks = 0;
    int   n_fail   = 0;
    int   run_cnt  = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [1:0] g, input logic [CNT_W-1:0] o, input int s);
        exp_t e;
        e.gnt   = g;
        e.out   = o;
        e.steps = s;
        sb_q.push_back(e);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        req = 2'b00;
        tick();
        rst = 1'b0;
        sb_q.delete();
    endtask

    // Completion monitor: every done pulse must match the oldest queued job.
    initial begin
        forever begin
            @(negedge clk);
            if (rst === 1'b1) begin
                run_cnt = 0;
            end else begin
                if (cnt_en === 1'b1) run_cnt++;
                chk("gnt_onehot", ($countones(gnt) <= 1), 1);
                if (done !== 2'b00) begin
                    if (sb_q.size() == 0) begin
                        chk("unexpected_done", done, 0);
                    end else begin
                        sb_e = sb_q.pop_front();
                        chk("sb_done", done, sb_e.gnt);
                        chk("sb_gnt", gnt, sb_e.gnt);
                        chk("sb_out", out, sb_e.out);
                        chk("sb_steps", run_cnt, sb_e.steps);
                    end
                    run_cnt = 0;
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [1:0] seq [3];
        logic [1:0] prev;
        int         ng;
        int         k;

        tbl[0] = '{2'b01, 2'b01, 4'd5,  4'd0, 2'b01, 4'd5};
        tbl[1] = '{2'b11, 2'b00, 4'd3,  4'd2, 2'b10, 4'd3};
        tbl[2] = '{2'b11, 2'b11, 4'd4,  4'd9, 2'b01, 4'd7};
        tbl[3] = '{2'b01, 2'b00, 4'd9,  4'd0, 2'b01, 4'd14};
        tbl[4] = '{2'b10, 2'b10, 4'd0,  4'd3, 2'b10, 4'd1};
        tbl[5] = '{2'b10, 2'b00, 4'd7,  4'd0, 2'b10, 4'd1};
        tbl[6] = '{2'b11, 2'b01, 4'd15, 4'd1, 2'b01, 4'd0};
        tbl[7] = '{2'b11, 2'b00, 4'd1,  4'd1, 2'b10, 4'd15};

        // Reset held with both requests pending
        rst = 1'b1; req = 2'b11; dir = 2'b11; steps0 = 4'd5; steps1 = 4'd5;
        for (int i = 0; i < 2; i++) begin
            tick();
            chk("rst_gnt", gnt, 0);
            chk("rst_out", out, 0);
            chk("rst_busy", busy, 0);
            chk("rst_done", done, 0);
            chk("rst_cnt_en", cnt_en, 0);
        end
        rst = 1'b0; req = 2'b00;

        // Job table: request, check grant, disturb inputs, await completion
        for (int i = 0; i < 8; i++) begin
            req = tbl[i].req; dir = tbl[i].dir; steps0 = tbl[i].s0; steps1 = tbl[i].s1;
            push(tbl[i].gnt, tbl[i].out, tbl[i].gnt[1] ? int'(tbl[i].s1) : int'(tbl[i].s0));
            tick();
            chk("tbl_gnt", gnt, tbl[i].gnt);
            chk("tbl_busy", busy, 1);
            req = 2'b00; dir = ~dir; steps0 = ~steps0; steps1 = ~steps1;
            k = 0;
            while (done === 2'b00 && k < 40) begin
                tick();
                k++;
            end
            chk("tbl_done_timeout", (k < 40), 1);
            chk("tbl_out", out, tbl[i].out);
            tick();
            chk("tbl_release_gnt", gnt, 0);
            chk("tbl_release_busy", busy, 0);
        end

        // Single up job, cycle by cycle
        do_reset();
        req = 2'b01; dir = 2'b01; steps0 = 4'd5; steps1 = 4'd0;
        push(2'b01, 4'd5, 5);
        tick();
        chk("up_gnt", gnt, 2'b01);
        chk("up_out0", out, 0);
        chk("up_cnt_en", cnt_en, 1);
        chk("up_sel", sel, 1);
        req = 2'b00;
        for (int s = 1; s <= 5; s++) begin
            tick();
            chk("up_out", out, s);
            chk("up_done", done, (s == 5) ? 2'b01 : 2'b00);
        end
        tick();
        chk("up_end_gnt", gnt, 0);
        chk("up_end_busy", busy, 0);
        chk("up_end_done", done, 0);

        // Down count wrapping through zero
        do_reset();
        req = 2'b01; dir = 2'b00; steps0 = 4'd3;
        push(2'b01, 4'd13, 3);
        tick();
        chk("wrap_cnt_en", cnt_en, 1);
        chk("wrap_sel", sel, 0);
        req = 2'b00;
        for (int s = 1; s <= 3; s++) begin
            tick();
            chk("wrap_out", out, 16 - s);
        end
        chk("wrap_done", done, 2'b01);
        tick();
        chk("wrap_end_gnt", gnt, 0);

        // Zero-step job
        do_reset();
        req = 2'b10; dir = 2'b00; steps1 = 4'd0;
        push(2'b10, 4'd0, 0);
        tick();
        chk("zero_gnt", gnt, 2'b10);
        chk("zero_done", done, 2'b10);
        chk("zero_cnt_en", cnt_en, 0);
        chk("zero_out", out, 0);
        req = 2'b00;
        tick();
        chk("zero_end_gnt", gnt, 0);
        chk("zero_end_done", done, 0);
        chk("zero_end_out", out, 0);

        // Round robin with both requests held
        do_reset();
        req = 2'b11; dir = 2'b11; steps0 = 4'd1; steps1 = 4'd1;
        push(2'b01, 4'd1, 1);
        push(2'b10, 4'd2, 1);
        push(2'b01, 4'd3, 1);
        seq[0] = 2'b00; seq[1] = 2'b00; seq[2] = 2'b00;
        prev = 2'b00; ng = 0;
        for (int c = 0; c < 30 && ng < 3; c++) begin
            tick();
            if (gnt !== 2'b00 && gnt !== prev) begin
                seq[ng] = gnt;
                ng++;
            end
            prev = gnt;
        end
        req = 2'b00;
        k = 0;
        while (busy !== 1'b0 && k < 20) begin
            tick();
            k++;
        end
        chk("rr_first", seq[0], 2'b01);
        chk("rr_second", seq[1], 2'b10);
        chk("rr_third", seq[2], 2'b01);
        chk("rr_drained", sb_q.size(), 0);

        // Reset in the middle of a run
        do_reset();
        req = 2'b01; dir = 2'b01; steps0 = 4'd6;
        tick();
        req = 2'b00;
        tick();
        tick();
        chk("abort_out_mid", out, 2);
        rst = 1'b1;
        tick();
        chk("abort_out", out, 0);
        chk("abort_gnt", gnt, 0);
        chk("abort_done", done, 0);
        chk("abort_busy", busy, 0);
        rst = 1'b0; req = 2'b11; dir = 2'b00; steps0 = 4'd0; steps1 = 4'd0;
        push(2'b01, 4'd0, 0);
        tick();
        chk("abort_regrant", gnt, 2'b01);
        req = 2'b00;
        tick();
        chk("abort_end_gnt", gnt, 0);
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
